// File: rtl/intc_cpu_responder.sv
// intc_cpu_responder
//   CPU-side end of the IRQ/IACK interrupt handshake. At an instruction boundary with
//   interrupts enabled it accepts a pending IRQ, saves the return PC in epc, pulses IACK,
//   captures the ISR entry address, redirects fetch into the ISR and, on ISR exit,
//   redirects fetch back to epc. No nesting: IRQ is ignored while inside an ISR.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   IRQ             level interrupt request, held until IACK
//   isr_addr        ISR entry address, valid while IRQ=1
//   int_enable      global interrupt enable
//   instr_boundary  core may be redirected this cycle
//   pc_next         return address to save on acceptance
//   isr_return      core executed the ISR-exit instruction
//   IACK            one-cycle acknowledge per accepted IRQ
//   pc_redirect     one-cycle strobe, core loads pc_target
//   pc_target       redirect target (ISR entry or epc), holds between redirects
//   epc             saved return PC
//   in_isr          high while executing the ISR
//   error           one-cycle pulse: stray isr_return or zero ISR vector
//   spurious_cnt    saturating count of IRQs withdrawn before acknowledge
module intc_cpu_responder #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IRQ,
   input  logic [ADDR_W-1:0] isr_addr,
   input  logic              int_enable,
   input  logic              instr_boundary,
   input  logic [ADDR_W-1:0] pc_next,
   input  logic              isr_return,
   output logic              IACK,
   output logic              pc_redirect,
   output logic [ADDR_W-1:0] pc_target,
   output logic [ADDR_W-1:0] epc,
   output logic              in_isr,
   output logic              error,
   output logic [CNT_W-1:0]  spurious_cnt
);

   typedef enum logic [2:0] {StIdle, StAck, StRedir, StInIsr, StRet} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  spur_q, spur_d;

   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      tgt_d   = tgt_q;
      err_d   = 1'b0;
      spur_d  = spur_q;
      unique case (state_q)
         StIdle: begin
            if (isr_return) err_d = 1'b1;
            if (IRQ && int_enable && instr_boundary) begin
               state_d = StAck;
               epc_d   = pc_next;
            end
         end
         StAck: begin
            if (IRQ) begin
               if (isr_addr == '0) begin
                  // Unconfigured vector: acknowledge but do not enter the ISR.
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  // The target register doubles as the ISR-address buffer so that
                  // pc_target keeps its last redirect value on the error path.
                  tgt_d   = isr_addr;
                  state_d = StRedir;
               end
            end else begin
               if (spur_q != '1) spur_d = spur_q + CNT_W'(1);
               state_d = StIdle;
            end
         end
         StRedir: state_d = StInIsr;
         StInIsr: begin
            // Return without a boundary is simply held off until the core can redirect.
            if (isr_return && instr_boundary) begin
               tgt_d   = epc_q;
               state_d = StRet;
            end
         end
         StRet:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         epc_q   <= '0;
         tgt_q   <= '0;
         err_q   <= 1'b0;
         spur_q  <= '0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         tgt_q   <= tgt_d;
         err_q   <= err_d;
         spur_q  <= spur_d;
      end
   end

   // Strobes are masked by rst so a reset cycle never emits IACK or a redirect.
   assign IACK         = (state_q == StAck) && IRQ && !rst;
   assign pc_redirect  = ((state_q == StRedir) || (state_q == StRet)) && !rst;
   assign pc_target    = tgt_q;
   assign epc          = epc_q;
   assign in_isr       = (state_q == StInIsr);
   assign error        = err_q;
   assign spurious_cnt = spur_q;

endmodule

// File: tb/tb_intc_cpu_responder.sv
module tb_intc_cpu_responder;

   logic        clk = 1'b0;
   logic        rst, IRQ, int_enable, instr_boundary, isr_return;
   logic [31:0] isr_addr, pc_next;
   logic        IACK, pc_redirect, in_isr, error;
   logic [31:0] pc_target, epc;
   logic [7:0]  spurious_cnt;

   always #5 clk = ~clk;

   intc_cpu_responder #(.ADDR_W(32), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .IRQ(IRQ), .isr_addr(isr_addr), .int_enable(int_enable),
      .instr_boundary(instr_boundary), .pc_next(pc_next), .isr_return(isr_return),
      .IACK(IACK), .pc_redirect(pc_redirect), .pc_target(pc_target), .epc(epc),
      .in_isr(in_isr), .error(error), .spurious_cnt(spurious_cnt)
   );

   typedef struct {
      logic        iack, redir, in_isr, err;
      logic [31:0] tgt, epc;
      logic [7:0]  spur;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: protocol events scheduled by absolute cycle number.
   int          cyc = 0;
   int          ack_at = -10, redir_at = -10, ret_at = -10, err_at = -10;
   bit          m_open = 0;
   logic [31:0] m_tgt = 0, m_epc = 0;
   int          m_spur = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("IACK", 32'(IACK), 32'(e.iack));
         check("pc_redirect", 32'(pc_redirect), 32'(e.redir));
         check("pc_target", pc_target, e.tgt);
         check("epc", epc, e.epc);
         check("in_isr", 32'(in_isr), 32'(e.in_isr));
         check("error", 32'(error), 32'(e.err));
         check("spurious_cnt", 32'(spurious_cnt), 32'(e.spur));
      end
   end

   task automatic step(input bit irq, input logic [31:0] addr, input bit en, input bit bnd,
                       input logic [31:0] pcn, input bit ret, input bit r);
      exp_t e;
      bit   was_open, idle;
      @(posedge clk);
      #1;
      IRQ = irq; isr_addr = addr; int_enable = en; instr_boundary = bnd;
      pc_next = pcn; isr_return = ret; rst = r;
      e.iack   = !r && (cyc == ack_at) && irq;
      e.redir  = !r && (cyc == redir_at || cyc == ret_at);
      e.tgt    = m_tgt;
      e.epc    = m_epc;
      e.in_isr = m_open;
      e.err    = (cyc == err_at);
      e.spur   = 8'(m_spur);
      exp_q.push_back(e);
      if (r) begin
         m_tgt = 0; m_epc = 0; m_spur = 0; m_open = 0;
         ack_at = -10; redir_at = -10; ret_at = -10; err_at = -10;
      end else begin
         was_open = m_open;
         idle = (cyc != ack_at) && (cyc != redir_at) && (cyc != ret_at) && !was_open;
         if (idle) begin
            if (ret) err_at = cyc + 1;
            if (irq && en && bnd) begin
               ack_at = cyc + 1;
               m_epc  = pcn;
            end
         end
         if (cyc == ack_at) begin
            if (!irq) begin
               if (m_spur < 255) m_spur++;
            end else if (addr == 0) begin
               err_at = cyc + 1;
            end else begin
               redir_at = cyc + 1;
               m_tgt    = addr;
            end
         end
         if (cyc == redir_at) m_open = 1;
         if (was_open && ret && bnd) begin
            ret_at = cyc + 1;
            m_tgt  = m_epc;
            m_open = 0;
         end
      end
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1, 1, 32'h0, 0, 0);
   endtask

   initial begin
      rst = 1; IRQ = 0; isr_addr = 0; int_enable = 0; instr_boundary = 0;
      pc_next = 0; isr_return = 0;
      repeat (2) @(posedge clk);

      // Reset state, then the basic accept / ISR / return sequence.
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 32'h400, 1, 1, 32'h100, 0, 0);
      step(1, 32'h400, 1, 1, 32'h104, 0, 0);
      idle_cycles(4);
      step(0, 0, 1, 0, 32'h500, 1, 0);
      step(0, 0, 1, 1, 32'h504, 1, 0);
      idle_cycles(3);

      // Gating: enable low, then boundary low.
      for (int i = 0; i < 10; i++) step(1, 32'h800, 0, 1, 32'h200, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 32'h800, 1, 0, 32'h200, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // Errors: stray return in idle, zero vector at ACK.
      step(0, 0, 1, 1, 0, 1, 0);
      idle_cycles(2);
      step(1, 32'h0, 1, 1, 32'h300, 0, 0);
      step(1, 32'h0, 1, 1, 32'h304, 0, 0);
      idle_cycles(3);

      // No nesting, then tail chain with IRQ held through RET.
      step(1, 32'h600, 1, 1, 32'h700, 0, 0);
      step(1, 32'h600, 1, 1, 32'h704, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 32'h900, 1, 1, 32'h610 + 32'(i), 0, 0);
      step(1, 32'h900, 1, 1, 32'h620, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 32'h900, 1, 1, 32'hA00 + 32'(i), 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 1, 0);
      idle_cycles(3);

      // Reset during REDIR and during IN_ISR.
      step(1, 32'h440, 1, 1, 32'h140, 0, 0);
      step(1, 32'h440, 1, 1, 32'h144, 0, 0);
      step(0, 0, 1, 1, 0, 0, 1);
      idle_cycles(3);
      step(1, 32'h480, 1, 1, 32'h180, 0, 0);
      step(1, 32'h480, 1, 1, 32'h184, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 1);
      idle_cycles(3);

      // Spurious: accept then withdraw, enough times to saturate.
      for (int i = 0; i < 260; i++) begin
         step(1, 32'h1000, 1, 1, 32'(i), 0, 0);
         step(0, 32'h1000, 1, 1, 32'(i), 0, 0);
      end
      idle_cycles(2);
      step(0, 0, 1, 1, 0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         bit          irq, en, bnd, ret, r;
         logic [31:0] addr;
         irq  = ($urandom_range(0, 99) < 50);
         en   = ($urandom_range(0, 99) < 75);
         bnd  = ($urandom_range(0, 99) < 60);
         ret  = ($urandom_range(0, 99) < 25);
         r    = ($urandom_range(0, 199) == 0);
         addr = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         step(irq, addr, en, bnd, $urandom, ret, r);
      end
      idle_cycles(2);

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
